muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes the two read-port operands and drives the register file write port (data, address, write enable) on completion.
- Multi-cycle: radix-2 shift-add multiplier and restoring divider, sharing one datapath.
- The control unit stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width. Only 32 is required to work.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- funct3  in  3  M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  in  XLEN  rs1 value (register file rd1)
- op_b  in  XLEN  rs2 value (register file rd2)
- rd_in  in  5  destination register index
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- result  out  XLEN  result; held stable until the next accepted start
- wb_we  out  1  register file write enable = done && (wb_addr != 0)
- wb_addr  out  5  latched rd_in

Behaviour:
- Reset: state IDLE; busy, done, wb_we = 0; result = 0; wb_addr = 0. Reset has priority in every state, including mid-operation; the aborted op produces no done and no write.
- One clock, one clock domain. Inputs are sampled only on the edge that accepts start.
- FSM states:
  - IDLE: on start, latch funct3, rd_in, abs/sign-adjusted operands and result-sign flag.
    - Div-by-zero or signed overflow -> FIN.
    - Otherwise -> CALC with counter = XLEN-1.
  - CALC: one iteration per cycle; counter decrements; at 0 -> FIN.
  - FIN: apply sign correction, select hi/lo or quotient/remainder, register result; done = 1 for this cycle only; -> IDLE.
- start in CALC or FIN is ignored; no queueing.
- A new start can be accepted in the IDLE cycle immediately after FIN.
- Latency, normal path: done high in the cycle XLEN+1 edges after the accepting edge (33 cycles), busy high for those cycles.
- Latency, fast path: done high in the cycle 1 edge after acceptance.
- Multiply:
  - 2*XLEN product from |a|, |b| per signedness: MULH both signed, MULHSU a signed / b unsigned, MULHU neither, MUL sign irrelevant.
  - Negate the 64-bit product if signs differ.
  - MUL returns the low word; all MULH* return the high word.
- Divide: restoring, 33-bit partial remainder.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a). Truncation toward zero.
- Division by zero: quotient = all ones; remainder = op_a unchanged (signed and unsigned).
- Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- result and wb_addr change only in FIN.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: MUL/MULH* with either operand zero takes the fast path (result 0, done 1 edge after acceptance).
- Undefined: zero operands take the full XLEN+1-cycle path, with identical result values.

Decomposition:
- muldiv_pkg:
  - funct3 op enum (MUL..REMU)
  - FSM state typedef {IDLE, CALC, FIN}
  - localparam for counter width $clog2(XLEN)
  - constants DIV_BY_ZERO_Q = '1 and SIGNED_MIN = 1<<(XLEN-1)
- Single module; no sub-module. The shared shift datapath stays inline.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after accept; wb_we=1 with wb_addr=rd_in=5.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, both with done 1 cycle after accept.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both on the fast path.
- Assert rst at CALC cycle 10 -> next cycle busy=0, done never pulses, no write.
- A start pulsed during CALC is ignored.
- rd_in=0 -> done=1, wb_we=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   op_e      : M-extension funct3 encoding (MUL..REMU)
//   state_e   : control FSM states (IDLE, CALC, FIN)
//   CNT_W     : iteration counter width, $clog2(XLEN)
//   DIV_BY_ZERO_Q / SIGNED_MIN : architectural special-case values
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [XLEN_DEF-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN_DEF-1:0] SIGNED_MIN    = XLEN_DEF'(1) << (XLEN_DEF - 1);

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiplier and
// restoring divider share one {hi, lo} shift datapath; one iteration per cycle.
// Sits between the register file read ports and its write port.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, sampled only in IDLE
//   funct3            : M-extension operation (see muldiv_pkg::op_e)
//   op_a, op_b        : rs1 / rs2 operands
//   rd_in             : destination register index
//   busy              : high from the cycle after accept until done
//   done              : one-cycle completion pulse
//   result            : result, held until the next completion
//   wb_we, wb_addr    : register file write enable / address
//
// Configuration macro MULDIV_EARLY_OUT_EN: when defined, a multiply with a zero
// operand completes one edge after acceptance instead of taking XLEN+1 edges.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_we,
  output logic [4:0]      wb_addr
);

  // Control state
  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        wb_addr_q, wb_addr_d;

  // Datapath state
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              q_neg_q, q_neg_d;   // product / quotient needs negation
  logic              r_neg_q, r_neg_d;   // remainder needs negation
  logic [XLEN-1:0]   hi_q, hi_d;         // product high word / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;         // multiplier -> product low / dividend -> quotient
  logic [XLEN-1:0]   opb_q, opb_d;       // |multiplicand| or |divisor|

  // ---------------------------------------------------------------------------
  // Operand decode on the accepting edge
  // ---------------------------------------------------------------------------
  op_e             op_in;
  logic            is_div_in, a_signed_in, b_signed_in;
  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            div_zero_in, div_ovf_in, mul_zero_in;

  assign op_in       = op_e'(funct3);
  assign is_div_in   = funct3[2];
  assign a_signed_in = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed_in = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign neg_a_in    = a_signed_in & op_a[XLEN-1];
  assign neg_b_in    = b_signed_in & op_b[XLEN-1];
  assign abs_a_in    = neg_a_in ? -op_a : op_a;
  assign abs_b_in    = neg_b_in ? -op_b : op_b;
  assign div_zero_in = is_div_in && (op_b == '0);
  assign div_ovf_in  = is_div_in && b_signed_in &&
                       (op_a == XLEN'(SIGNED_MIN)) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_zero_in = !is_div_in && ((op_a == '0) || (op_b == '0));
`else
  assign mul_zero_in = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // One iteration of the shared shift datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;   // hi + multiplicand, with carry that shifts into hi
  logic [XLEN:0]   div_shift; // 33-bit partial remainder after the left shift
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
  assign div_diff  = div_shift[XLEN-1:0] - opb_q;

  // ---------------------------------------------------------------------------
  // Final sign correction and result selection
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign prod_s = q_neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s  = q_neg_q ? -lo_q : lo_q;
  assign rem_s  = r_neg_q ? -hi_q : hi_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    done_d    = 1'b0;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_in;
          rd_d    = rd_in;
          q_neg_d = neg_a_in ^ neg_b_in;
          r_neg_d = neg_a_in;
          hi_d    = '0;
          lo_d    = abs_a_in;
          opb_d   = abs_b_in;
          cnt_d   = CNT_W'(XLEN - 1);
          state_d = CALC;
          // Special cases preload {hi, lo} so FIN's normal selection yields the
          // architectural answer with sign correction disabled.
          if (div_zero_in) begin
            hi_d    = op_a;
            lo_d    = XLEN'(DIV_BY_ZERO_Q);
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = FIN;
          end else if (div_ovf_in) begin
            hi_d    = '0;
            lo_d    = XLEN'(SIGNED_MIN);
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = FIN;
          end else if (mul_zero_in) begin
            hi_d    = '0;
            lo_d    = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = FIN;
          end
        end
      end

      CALC: begin
        if (op_q[2]) begin
          hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIN: begin
        done_d    = 1'b1;
        wb_addr_d = rd_q;
        state_d   = IDLE;
        unique case (op_q)
          OP_MUL:                       result_d = prod_s[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_d = quo_s;
          default:                      result_d = rem_s;
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  // NOTE: datapath registers are deliberately not reset; they are always
  // loaded on the accepting edge before anything reads them.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    op_q    <= op_d;
    rd_q    <= rd_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    opb_q   <= opb_d;
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;
  assign wb_we   = done_q && (wb_addr_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed-vector bench for muldiv_unit. The stimulus process pushes the
// hand-computed expected response into a scoreboard queue when each request is
// accepted; an independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3,
                         F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  localparam int LAT_FULL = 33;
  localparam int LAT_FAST = 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_MUL0 = LAT_FAST;
`else
  localparam int LAT_MUL0 = LAT_FULL;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wb_we   (wb_we),
    .wb_addr (wb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic [4:0]  addr;
    int          lat;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result",  64'(result),  64'(mon_e.res));
        check("wb_we",   64'(wb_we),   64'(mon_e.we));
        check("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
        check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  // Issue one request from a negedge, wait (bounded) for its done pulse and
  // return at the negedge where done is high, so the next call is back-to-back.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res,
                       input int lat, input bit poke);
    int  busy_cnt;
    bit  seen;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{res: exp_res, we: (rd != 5'd0), addr: rd, lat: lat, acc: cyc});
    start    = 1'b0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 5) begin
        // Request during CALC must be ignored.
        funct3 = F_DIVU;
        op_a   = 32'd1;
        op_b   = 32'd0;
        rd_in  = 5'd9;
        start  = 1'b1;
      end
      if (poke && i == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else       check("busy_cycles", 64'(busy_cnt), 64'(lat));
  endtask

  int bad_cnt;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_wb_we",   64'(wb_we),   64'd0);
    check("rst_result",  64'(result),  64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    //    funct3    op_a          op_b          rd     expected      latency   poke
    issue(F_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT_FULL, 1'b0);
    issue(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, LAT_FULL, 1'b0);
    issue(F_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, LAT_FULL, 1'b0);
    issue(F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000000, LAT_FULL, 1'b0);
    issue(F_MULH,   32'h80000000, 32'h80000000, 5'd11, 32'h40000000, LAT_FULL, 1'b1);
    issue(F_DIV,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, LAT_FULL, 1'b0);
    issue(F_REM,    32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, LAT_FULL, 1'b0);
    issue(F_DIV,    32'd7,        32'hFFFFFFFD, 5'd14, 32'hFFFFFFFE, LAT_FULL, 1'b0);
    issue(F_REM,    32'd7,        32'hFFFFFFFD, 5'd15, 32'h00000001, LAT_FULL, 1'b0);
    issue(F_DIV,    32'h80000000, 32'd1,        5'd16, 32'h80000000, LAT_FULL, 1'b0);
    issue(F_DIVU,   32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, LAT_FAST, 1'b0);
    issue(F_REMU,   32'd5,        32'd0,        5'd18, 32'h00000005, LAT_FAST, 1'b0);
    issue(F_REM,    32'hFFFFFFF9, 32'd0,        5'd19, 32'hFFFFFFF9, LAT_FAST, 1'b0);
    issue(F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, LAT_FAST, 1'b0);
    issue(F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h00000000, LAT_FAST, 1'b0);
    issue(F_MUL,    32'd3,        32'd4,        5'd0,  32'h0000000C, LAT_FULL, 1'b0);
    issue(F_MUL,    32'd0,        32'd5,        5'd22, 32'h00000000, LAT_MUL0, 1'b0);

    // Reset in the middle of CALC: no completion, no write.
    funct3 = F_MUL;
    op_a   = 32'h12345678;
    op_b   = 32'd3;
    rd_in  = 5'd10;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    bad_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || wb_we) bad_cnt++;
    end
    check("abort_no_write", 64'(bad_cnt), 64'd0);

    // Recovery after the abort, then result must hold while idle.
    issue(F_DIVU,   32'd100,      32'd7,        5'd23, 32'h0000000E, LAT_FULL, 1'b0);
    issue(F_REMU,   32'd100,      32'd7,        5'd24, 32'h00000002, LAT_FULL, 1'b0);
    repeat (5) @(negedge clk);
    check("result_hold", 64'(result), 64'h2);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
